wra_seq_ctrl: RTL and testbench
===============================

# wra_seq_ctrl

Parametrised layer-sequencing controller that replaces the RISC core in front of N_ENG parallel WRA engines. It fetches and decodes instructions, loads configuration, data and filters, starts a per-instruction subset of engines and waits for all of them to finish. It also reads results out, counts completed layers and optionally guards every wait state with a watchdog. It sits between the asynchronous input FIFO / decoder and the DMA_WRA, WRA array and ResultAccess blocks.

## Interface
- N_ENG, 4: number of WRA engines (1..16)
- LCNT_W, 8: width of the completed-layer counter
- TMO_W, 16: watchdog counter width
- TMO_CYC, 16'hFFFF: watchdog limit in cycles (must fit in TMO_W)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_full  in  1  asynchronous FIFO full (instruction batch ready)
- model_done  in  1  decoder: end of model
- read_result  in  1  decoder: current instruction is a result read
- eng_mask  in  N_ENG  decoder: engines used by current instruction
- data_pre_done  in  1  DMA_WRA: data/filter load complete
- layer_done  in  N_ENG  per-engine layer-done pulse or level
- output_rd_done  in  1  ResultAccess: readout complete
- abort  in  1  synchronous abort, return to IDLE
- wra_start  out  N_ENG  one-cycle start, per engine
- data_en, filter_en, cfg_en, result_rd_en, pc_en  out  1 each  enables to DMA_WRA / ResultAccess / PC+decoder
- busy  out  1  state != IDLE
- layer_cnt  out  LCNT_W  completed layers since last model start
- err  out  1  sticky watchdog error
- state  out  4  current state code, for debug

## Operation
- States and codes: IDLE=0, READINSTR=1, DECODE=2, LOADDATA=3, STARTWRA=4, RUNWRA=5, READRESULT=6, ERROR=7.
- Outputs are Moore outputs, registered from the decode of next_state, so they are valid in the same cycle as the state they belong to:
  - READINSTR: pc_en=1
  - DECODE: cfg_en=1
  - LOADDATA: data_en=filter_en=1
  - STARTWRA: wra_start=mask_q
  - READRESULT: result_rd_en=1
  - all other outputs 0
- Transitions:
  - IDLE -> READINSTR on fifo_full; layer_cnt cleared on this transition.
  - READINSTR -> DECODE unconditionally.
  - DECODE, priority order: model_done -> IDLE; else read_result -> READRESULT; else eng_mask==0 -> READINSTR (NOP, no count); else LOADDATA, with mask_q<=eng_mask.
  - LOADDATA -> STARTWRA on data_pre_done.
  - STARTWRA -> RUNWRA unconditionally.
  - RUNWRA -> READINSTR when ((done_seen|layer_done)&mask_q)==mask_q; layer_cnt increments on this transition and saturates at all-ones.
  - READRESULT -> READINSTR on output_rd_done.
  - ERROR holds until abort.
- done_seen: cleared in STARTWRA; ORs in layer_done&mask_q during STARTWRA and RUNWRA. An engine finishing early or in the same cycle as its start is therefore never lost. Done bits of unmasked engines are ignored.
- abort has highest priority in every state: next state is IDLE, done_seen and err are cleared, layer_cnt is held.
- Unused state codes go to IDLE.

## Timing
- Reset: all outputs 0, state=IDLE, mask_q=0, done_seen=0, layer_cnt=0, err=0.
- fifo_full is sampled at edge k -> pc_en is high in cycle k+1 and cfg_en in cycle k+2.
- Minimum layer: LOADDATA, then STARTWRA (exactly 1 cycle), then RUNWRA (at least 1 cycle).
- Minimum RUNWRA exit latency is 1 cycle after all masked done bits are seen.
- All decoder inputs are sampled only in DECODE; other inputs are sampled only in the state that waits on them.

## Configuration
- WRA_SEQ_WDT_EN defined:
  - A TMO_W-bit counter clears on entry to LOADDATA, RUNWRA or READRESULT and increments each cycle spent in those states.
  - When it reaches TMO_CYC the FSM goes to ERROR and err<=1.
  - abort has priority over the timeout.
- WRA_SEQ_WDT_EN undefined: no counter is built, ERROR is unreachable and err is tied to 0.

## Test plan
- Reset mid-RUNWRA -> all outputs 0 asynchronously; state=0 and layer_cnt=0 after release.
- fifo_full=1, eng_mask=4'b0101, data_pre_done after 3 cycles, then layer_done[0] and layer_done[2] 5 cycles apart -> wra_start=4'b0101 for one cycle; exit only after the second done; layer_cnt=1.
- layer_done=4'b0001 during STARTWRA, layer_done=4'b0100 two cycles later -> RUNWRA exits; an unmasked layer_done[1] alone never exits.
- DECODE with model_done=1 and read_result=1 -> IDLE; with read_result=1 and eng_mask=0 -> READRESULT; with eng_mask=0 only -> READINSTR and layer_cnt unchanged.
- WRA_SEQ_WDT_EN, TMO_CYC=16, data_pre_done held 0 -> state=7 and err=1 after 16 LOADDATA cycles; abort -> IDLE with err=0 next cycle.
- 300 layers with LCNT_W=8 -> layer_cnt saturates at 255.

Source files
------------

// File: rtl/wra_seq_ctrl.sv
// Layer-sequencing controller for N_ENG parallel WRA engines: fetch, decode, load, start, wait.
// Define WRA_SEQ_WDT_EN to build the wait-state watchdog and the ERROR path.
module wra_seq_ctrl #(
   parameter int unsigned       N_ENG   = 4,
   parameter int unsigned       LCNT_W  = 8,
   parameter int unsigned       TMO_W   = 16,
   parameter logic [TMO_W-1:0]  TMO_CYC = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_full,
   input  logic              model_done,
   input  logic              read_result,
   input  logic [N_ENG-1:0]  eng_mask,
   input  logic              data_pre_done,
   input  logic [N_ENG-1:0]  layer_done,
   input  logic              output_rd_done,
   input  logic              abort,
   output logic [N_ENG-1:0]  wra_start,
   output logic              data_en,
   output logic              filter_en,
   output logic              cfg_en,
   output logic              result_rd_en,
   output logic              pc_en,
   output logic              busy,
   output logic [LCNT_W-1:0] layer_cnt,
   output logic              err,
   output logic [3:0]        state
);

   typedef enum logic [3:0] {
      StIdle       = 4'd0,
      StReadInstr  = 4'd1,
      StDecode     = 4'd2,
      StLoadData   = 4'd3,
      StStartWra   = 4'd4,
      StRunWra     = 4'd5,
      StReadResult = 4'd6,
      StError      = 4'd7
   } state_e;

   state_e              state_q, state_d;
   logic [N_ENG-1:0]    mask_q, mask_d;
   logic [N_ENG-1:0]    done_seen_q, done_seen_d;
   logic [LCNT_W-1:0]   layer_cnt_q, layer_cnt_d;
   logic [N_ENG-1:0]    wra_start_q, wra_start_d;
   logic                load_en_q, load_en_d;
   logic                cfg_en_q, cfg_en_d;
   logic                result_rd_en_q, result_rd_en_d;
   logic                pc_en_q, pc_en_d;
   logic                all_done;
   logic                wdt_expired;

   // A done pulse that arrives this cycle counts as well as the ones already latched.
   assign all_done = (((done_seen_q | layer_done) & mask_q) == mask_q);

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      done_seen_d = done_seen_q;
      layer_cnt_d = layer_cnt_q;
      case (state_q)
         StIdle: begin
            if (fifo_full) begin
               state_d     = StReadInstr;
               layer_cnt_d = '0;
            end
         end
         StReadInstr: state_d = StDecode;
         StDecode: begin
            if (model_done) begin
               state_d = StIdle;
            end else if (read_result) begin
               state_d = StReadResult;
            end else if (eng_mask == '0) begin
               state_d = StReadInstr;
            end else begin
               state_d = StLoadData;
               mask_d  = eng_mask;
            end
         end
         StLoadData: begin
            if (data_pre_done) state_d = StStartWra;
         end
         StStartWra: begin
            state_d     = StRunWra;
            done_seen_d = layer_done & mask_q;
         end
         StRunWra: begin
            done_seen_d = done_seen_q | (layer_done & mask_q);
            if (all_done) begin
               state_d = StReadInstr;
               if (layer_cnt_q != '1) begin
                  layer_cnt_d = layer_cnt_q + {{(LCNT_W-1){1'b0}}, 1'b1};
               end
            end
         end
         StReadResult: begin
            if (output_rd_done) state_d = StReadInstr;
         end
         StError: state_d = StError;
         default: state_d = StIdle;
      endcase
      if (wdt_expired) begin
         state_d     = StError;
         layer_cnt_d = layer_cnt_q;
      end
      if (abort) begin
         state_d     = StIdle;
         done_seen_d = '0;
         layer_cnt_d = layer_cnt_q;
      end
   end

   // Outputs are decoded from the next state so they line up with the state they belong to.
   always_comb begin
      wra_start_d    = '0;
      load_en_d      = 1'b0;
      cfg_en_d       = 1'b0;
      result_rd_en_d = 1'b0;
      pc_en_d        = 1'b0;
      case (state_d)
         StReadInstr:  pc_en_d        = 1'b1;
         StDecode:     cfg_en_d       = 1'b1;
         StLoadData:   load_en_d      = 1'b1;
         StStartWra:   wra_start_d    = mask_q;
         StReadResult: result_rd_en_d = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         mask_q         <= '0;
         done_seen_q    <= '0;
         layer_cnt_q    <= '0;
         wra_start_q    <= '0;
         load_en_q      <= 1'b0;
         cfg_en_q       <= 1'b0;
         result_rd_en_q <= 1'b0;
         pc_en_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         done_seen_q    <= done_seen_d;
         layer_cnt_q    <= layer_cnt_d;
         wra_start_q    <= wra_start_d;
         load_en_q      <= load_en_d;
         cfg_en_q       <= cfg_en_d;
         result_rd_en_q <= result_rd_en_d;
         pc_en_q        <= pc_en_d;
      end
   end

`ifdef WRA_SEQ_WDT_EN
   logic [TMO_W-1:0] wdt_q, wdt_d;
   logic             err_q, err_d;
   logic             wdt_active;
   logic             wdt_entry;

   assign wdt_active  = (state_q == StLoadData) || (state_q == StRunWra) ||
                        (state_q == StReadResult);
   assign wdt_entry   = (state_d != state_q) && ((state_d == StLoadData) ||
                        (state_d == StRunWra) || (state_d == StReadResult));
   // Counter holds the number of cycles already spent; the TMO_CYC-th cycle trips it.
   assign wdt_expired = wdt_active && (wdt_q == TMO_W'(TMO_CYC - 1'b1));

   always_comb begin
      wdt_d = wdt_q;
      err_d = err_q;
      if (wdt_entry) begin
         wdt_d = '0;
      end else if (wdt_active) begin
         wdt_d = wdt_q + {{(TMO_W-1){1'b0}}, 1'b1};
      end
      if (abort) begin
         err_d = 1'b0;
      end else if (wdt_expired) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wdt_q <= wdt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_wdt_cfg;
   assign unused_wdt_cfg = ^TMO_CYC;
   assign wdt_expired    = 1'b0;
   assign err            = 1'b0;
`endif

   assign wra_start    = wra_start_q;
   assign data_en      = load_en_q;
   assign filter_en    = load_en_q;
   assign cfg_en       = cfg_en_q;
   assign result_rd_en = result_rd_en_q;
   assign pc_en        = pc_en_q;
   assign busy         = (state_q != StIdle);
   assign layer_cnt    = layer_cnt_q;
   assign state        = state_q;

endmodule

// File: tb/tb_wra_seq_ctrl.sv
// Self-checking bench for wra_seq_ctrl; wra_start pulses are scored against an expected-mask queue.
module tb_wra_seq_ctrl;

   localparam int unsigned N_ENG  = 4;
   localparam int unsigned LCNT_W = 8;

   logic              clk;
   logic              rst_n;
   logic              fifo_full;
   logic              model_done;
   logic              read_result;
   logic [N_ENG-1:0]  eng_mask;
   logic              data_pre_done;
   logic [N_ENG-1:0]  layer_done;
   logic              output_rd_done;
   logic              abort;
   logic [N_ENG-1:0]  wra_start;
   logic              data_en;
   logic              filter_en;
   logic              cfg_en;
   logic              result_rd_en;
   logic              pc_en;
   logic              busy;
   logic [LCNT_W-1:0] layer_cnt;
   logic              err;
   logic [3:0]        state;

   int                checks;
   int                failures;
   logic [N_ENG-1:0]  exp_start_q[$];
   logic [N_ENG-1:0]  exp_m;

   wra_seq_ctrl #(
      .N_ENG   (N_ENG),
      .LCNT_W  (LCNT_W),
      .TMO_W   (16),
      .TMO_CYC (16'd16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_full      (fifo_full),
      .model_done     (model_done),
      .read_result    (read_result),
      .eng_mask       (eng_mask),
      .data_pre_done  (data_pre_done),
      .layer_done     (layer_done),
      .output_rd_done (output_rd_done),
      .abort          (abort),
      .wra_start      (wra_start),
      .data_en        (data_en),
      .filter_en      (filter_en),
      .cfg_en         (cfg_en),
      .result_rd_en   (result_rd_en),
      .pc_en          (pc_en),
      .busy           (busy),
      .layer_cnt      (layer_cnt),
      .err            (err),
      .state          (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every non-zero wra_start cycle must match the next expected mask.
   always @(negedge clk) begin
      if (rst_n && (wra_start !== '0)) begin
         checks++;
         if (exp_start_q.size() == 0) begin
            failures++;
            $display("FAIL wra_start_unexpected actual=%b required=0000", wra_start);
         end else begin
            exp_m = exp_start_q.pop_front();
            if (wra_start !== exp_m) begin
               failures++;
               $display("FAIL wra_start actual=%b required=%b", wra_start, exp_m);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [3:0] target, input int budget, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < budget) begin
         if (state === target) ok = 1'b1;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({state, busy, layer_cnt, err} !== '0) begin
         failures++;
         $display("FAIL reset_state actual=%0d/%0d/%0d/%0d required=0/0/0/0",
                  state, busy, layer_cnt, err);
      end
      checks++;
      if ({wra_start, data_en, filter_en, cfg_en, result_rd_en, pc_en} !== '0) begin
         failures++;
         $display("FAIL reset_outputs actual=%b required=0",
                  {wra_start, data_en, filter_en, cfg_en, result_rd_en, pc_en});
      end
      #3 rst_n = 1'b1;
      tick();
      checks++;
      if (state !== 4'd0) begin
         failures++;
         $display("FAIL reset_release_state actual=%0d required=0", state);
      end
   endtask

   task automatic test_basic_layer();
      fifo_full = 1'b1;
      tick();
      checks++;
      if (state !== 4'd1 || pc_en !== 1'b1) begin
         failures++;
         $display("FAIL basic_readinstr actual=%0d/%b required=1/1", state, pc_en);
      end
      fifo_full = 1'b0;
      eng_mask  = 4'b0101;
      tick();
      checks++;
      if (state !== 4'd2 || cfg_en !== 1'b1 || pc_en !== 1'b0) begin
         failures++;
         $display("FAIL basic_decode actual=%0d/%b/%b required=2/1/0", state, cfg_en, pc_en);
      end
      exp_start_q.push_back(4'b0101);
      tick();
      tick();
      tick();
      checks++;
      if (state !== 4'd3 || data_en !== 1'b1 || filter_en !== 1'b1) begin
         failures++;
         $display("FAIL basic_loaddata actual=%0d/%b/%b required=3/1/1",
                  state, data_en, filter_en);
      end
      data_pre_done = 1'b1;
      tick();
      checks++;
      if (state !== 4'd4) begin
         failures++;
         $display("FAIL basic_startwra actual=%0d required=4", state);
      end
      data_pre_done = 1'b0;
      eng_mask      = '0;
      tick();
      checks++;
      if (state !== 4'd5 || wra_start !== '0) begin
         failures++;
         $display("FAIL basic_runwra actual=%0d/%b required=5/0000", state, wra_start);
      end
      layer_done = 4'b0001;
      tick();
      layer_done = '0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (state !== 4'd5) begin
            failures++;
            $display("FAIL basic_wait_second_done actual=%0d required=5", state);
         end
         tick();
      end
      layer_done = 4'b0100;
      tick();
      layer_done = '0;
      checks++;
      if (state !== 4'd1 || layer_cnt !== 8'd1) begin
         failures++;
         $display("FAIL basic_exit actual=%0d/%0d required=1/1", state, layer_cnt);
      end
      model_done = 1'b1;
      tick();
      tick();
      model_done = 1'b0;
      checks++;
      if (state !== 4'd0 || busy !== 1'b0 || layer_cnt !== 8'd1) begin
         failures++;
         $display("FAIL basic_idle actual=%0d/%b/%0d required=0/0/1", state, busy, layer_cnt);
      end
   endtask

   task automatic test_early_done();
      fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      eng_mask  = 4'b0101;
      tick();
      exp_start_q.push_back(4'b0101);
      data_pre_done = 1'b1;
      tick();
      tick();
      data_pre_done = 1'b0;
      layer_done    = 4'b0001;
      tick();
      checks++;
      if (state !== 4'd5 || layer_cnt !== 8'd0) begin
         failures++;
         $display("FAIL early_runwra actual=%0d/%0d required=5/0", state, layer_cnt);
      end
      layer_done = 4'b0010;
      tick();
      checks++;
      if (state !== 4'd5) begin
         failures++;
         $display("FAIL early_unmasked_hold actual=%0d required=5", state);
      end
      layer_done = 4'b0100;
      tick();
      layer_done = '0;
      checks++;
      if (state !== 4'd1 || layer_cnt !== 8'd1) begin
         failures++;
         $display("FAIL early_exit actual=%0d/%0d required=1/1", state, layer_cnt);
      end
      tick();
      exp_start_q.push_back(4'b0101);
      data_pre_done = 1'b1;
      tick();
      tick();
      data_pre_done = 1'b0;
      layer_done    = 4'b0010;
      tick();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (state !== 4'd5) begin
            failures++;
            $display("FAIL unmasked_only_exit actual=%0d required=5", state);
         end
         tick();
      end
      abort = 1'b1;
      tick();
      abort      = 1'b0;
      layer_done = '0;
      eng_mask   = '0;
      checks++;
      if (state !== 4'd0 || busy !== 1'b0 || layer_cnt !== 8'd1) begin
         failures++;
         $display("FAIL abort_runwra actual=%0d/%b/%0d required=0/0/1", state, busy, layer_cnt);
      end
   endtask

   task automatic test_decode();
      fifo_full = 1'b1;
      tick();
      fifo_full   = 1'b0;
      model_done  = 1'b1;
      read_result = 1'b1;
      eng_mask    = 4'b0101;
      tick();
      tick();
      checks++;
      if (state !== 4'd0) begin
         failures++;
         $display("FAIL decode_model_done actual=%0d required=0", state);
      end
      model_done = 1'b0;
      eng_mask   = '0;
      fifo_full  = 1'b1;
      tick();
      fifo_full = 1'b0;
      tick();
      tick();
      checks++;
      if (state !== 4'd6 || result_rd_en !== 1'b1 || layer_cnt !== 8'd0) begin
         failures++;
         $display("FAIL decode_read_result actual=%0d/%b/%0d required=6/1/0",
                  state, result_rd_en, layer_cnt);
      end
      read_result = 1'b0;
      tick();
      checks++;
      if (state !== 4'd6) begin
         failures++;
         $display("FAIL readresult_hold actual=%0d required=6", state);
      end
      output_rd_done = 1'b1;
      tick();
      output_rd_done = 1'b0;
      checks++;
      if (state !== 4'd1 || result_rd_en !== 1'b0) begin
         failures++;
         $display("FAIL readresult_exit actual=%0d/%b required=1/0", state, result_rd_en);
      end
      tick();
      tick();
      checks++;
      if (state !== 4'd1 || layer_cnt !== 8'd0) begin
         failures++;
         $display("FAIL decode_nop actual=%0d/%0d required=1/0", state, layer_cnt);
      end
      model_done = 1'b1;
      tick();
      tick();
      model_done = 1'b0;
   endtask

   task automatic test_back_to_back_saturation();
      bit ok;
      logic [N_ENG-1:0] m;
      fifo_full = 1'b1;
      tick();
      fifo_full     = 1'b0;
      data_pre_done = 1'b1;
      for (int i = 0; i < 300; i++) begin
         m          = (i % 2 == 1) ? 4'b1110 : 4'b0001;
         eng_mask   = m;
         layer_done = m;
         wait_state(4'd2, 10, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL sat_reach_decode actual=%0d required=2", state);
         end
         exp_start_q.push_back(m);
         tick();
         wait_state(4'd1, 10, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL sat_layer_exit actual=%0d required=1", state);
         end
         if (i == 99) begin
            checks++;
            if (layer_cnt !== 8'd100) begin
               failures++;
               $display("FAIL sat_count_100 actual=%0d required=100", layer_cnt);
            end
         end
      end
      checks++;
      if (layer_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_count_255 actual=%0d required=255", layer_cnt);
      end
      model_done = 1'b1;
      wait_state(4'd0, 10, ok);
      model_done    = 1'b0;
      data_pre_done = 1'b0;
      layer_done    = '0;
      eng_mask      = '0;
      checks++;
      if (!ok || layer_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_idle actual=%0d/%0d required=0/255", state, layer_cnt);
      end
   endtask

   task automatic test_watchdog();
      int stay;
      fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      eng_mask  = 4'b0001;
      tick();
      tick();
      stay = 0;
      for (int k = 0; k < 16; k++) begin
         if (state === 4'd3) stay++;
         tick();
      end
      checks++;
      if (stay != 16) begin
         failures++;
         $display("FAIL wdt_loaddata_cycles actual=%0d required=16", stay);
      end
`ifdef WRA_SEQ_WDT_EN
      checks++;
      if (state !== 4'd7 || err !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wdt_error actual=%0d/%b required=7/1", state, err);
      end
      tick();
      checks++;
      if (state !== 4'd7) begin
         failures++;
         $display("FAIL wdt_error_hold actual=%0d required=7", state);
      end
`else
      checks++;
      if (state !== 4'd3 || err !== 1'b0) begin
         failures++;
         $display("FAIL nowdt_hold actual=%0d/%b required=3/0", state, err);
      end
`endif
      abort = 1'b1;
      tick();
      abort    = 1'b0;
      eng_mask = '0;
      checks++;
      if (state !== 4'd0 || err !== 1'b0) begin
         failures++;
         $display("FAIL wdt_abort actual=%0d/%b required=0/0", state, err);
      end
   endtask

   task automatic test_reset_mid_run();
      fifo_full = 1'b1;
      tick();
      fifo_full     = 1'b0;
      eng_mask      = 4'b0011;
      data_pre_done = 1'b1;
      layer_done    = 4'b0011;
      tick();
      exp_start_q.push_back(4'b0011);
      tick();
      tick();
      tick();
      tick();
      layer_done = '0;
      tick();
      exp_start_q.push_back(4'b0011);
      tick();
      tick();
      tick();
      checks++;
      if (state !== 4'd5 || layer_cnt !== 8'd1) begin
         failures++;
         $display("FAIL midrun_setup actual=%0d/%0d required=5/1", state, layer_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({state, busy, layer_cnt, wra_start, data_en, filter_en, cfg_en, result_rd_en,
           pc_en, err} !== '0) begin
         failures++;
         $display("FAIL midrun_async_reset actual=%0d/%b/%0d required=0/0/0",
                  state, busy, layer_cnt);
      end
      data_pre_done = 1'b0;
      eng_mask      = '0;
      #3 rst_n = 1'b1;
      tick();
      checks++;
      if (state !== 4'd0 || layer_cnt !== 8'd0) begin
         failures++;
         $display("FAIL midrun_release actual=%0d/%0d required=0/0", state, layer_cnt);
      end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      fifo_full      = 1'b0;
      model_done     = 1'b0;
      read_result    = 1'b0;
      eng_mask       = '0;
      data_pre_done  = 1'b0;
      layer_done     = '0;
      output_rd_done = 1'b0;
      abort          = 1'b0;
      #20;
      test_reset();
      test_basic_layer();
      test_early_done();
      test_decode();
      test_back_to_back_saturation();
      test_watchdog();
      test_reset_mid_run();
      repeat (3) tick();
      checks++;
      if (exp_start_q.size() != 0) begin
         failures++;
         $display("FAIL wra_start_missing actual=%0d required=0", exp_start_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
